mc_ctrl_fsm: RTL and testbench

- Multi-cycle main controller for the MIPS core; sits directly upstream of the ALU.
- Decodes the latched instruction's opcode/funct into the 4-bit ALU operation code and the per-state datapath strobes: PC, IR, memory, register file and operand muxes.
- Consumes the ALU equality flag for branch resolution.
- Sequences one instruction through FETCH → DECODE → EXEC/MEM/WB states.

---
 rtl/mips_pkg.sv | 86 ++++++++
 rtl/mc_alu_dec.sv | 67 ++++++
 rtl/mc_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multi-cycle MIPS controller slice:
//   - state_e      : controller state encoding (also exported on state_o)
//   - ALU_*        : 4-bit ALU operation codes understood by the ALU
//   - OP_* / FN_*  : instruction opcode (IR[31:26]) and funct (IR[5:0]) values
//   - PC_SRC_*, SRC_A_*, SRC_B_*, IORD_*, REG_DST_*, WB_* : datapath mux selects
package mips_pkg;

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_R_WB     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_I_WB     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_MEM_WB   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_ILLEGAL  = 4'd13
  } state_e;

  localparam logic [3:0] ALU_ADDU  = 4'd0;
  localparam logic [3:0] ALU_SUBU  = 4'd1;
  localparam logic [3:0] ALU_ORI   = 4'd2;
  localparam logic [3:0] ALU_ADD   = 4'd3;
  localparam logic [3:0] ALU_SUB   = 4'd4;
  localparam logic [3:0] ALU_AND   = 4'd5;
  localparam logic [3:0] ALU_OR    = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_NOR   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;
  localparam logic [3:0] ALU_ADDI  = 4'd11;
  localparam logic [3:0] ALU_ADDIU = 4'd12;
  localparam logic [3:0] ALU_ANDI  = 4'd13;
  localparam logic [3:0] ALU_XORI  = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic       IORD_PC     = 1'b0;
  localparam logic       IORD_ALUOUT = 1'b1;

  localparam logic       REG_DST_RT = 1'b0;
  localparam logic       REG_DST_RD = 1'b1;

  localparam logic       WB_ALUOUT = 1'b0;
  localparam logic       WB_MDR    = 1'b1;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec
// Combinational ALU operation decoder for the multi-cycle controller.
// Ports:
//   state_i       in  4  current controller state
//   opcode_i      in  6  instruction opcode
//   funct_i       in  6  instruction funct field
//   alu_op_o      out 4  ALU operation code for this state
//   funct_valid_o out 1  funct is one of the supported R-type functions
module mc_alu_dec
  import mips_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       funct_valid_o
);

  logic [3:0] r_op;
  logic [3:0] i_op;

  // R-type funct to ALU op; unsupported functs fall back to ADDU and are
  // flagged so the FSM can divert to ILLEGAL instead of writing back.
  always_comb begin
    r_op          = ALU_ADDU;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  r_op = ALU_ADD;
      FN_ADDU: r_op = ALU_ADDU;
      FN_SUB:  r_op = ALU_SUB;
      FN_SUBU: r_op = ALU_SUBU;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLT:  r_op = ALU_SLT;
      FN_SLTU: r_op = ALU_SLTU;
      default: funct_valid_o = 1'b0;
    endcase
  end

  // Immediate-format opcode to ALU op.
  always_comb begin
    i_op = ALU_ADDU;
    case (opcode_i)
      OP_ADDI:  i_op = ALU_ADDI;
      OP_ADDIU: i_op = ALU_ADDIU;
      OP_ANDI:  i_op = ALU_ANDI;
      OP_ORI:   i_op = ALU_ORI;
      OP_XORI:  i_op = ALU_XORI;
      default:  i_op = ALU_ADDU;
    endcase
  end

  // Per-state selection: only the execute and branch states use anything
  // other than ADDU (PC+4, branch target and address arithmetic are all adds).
  always_comb begin
    alu_op_o = ALU_ADDU;
    case (state_i)
      ST_EXEC_R: alu_op_o = r_op;
      ST_EXEC_I: alu_op_o = i_op;
      ST_BRANCH: alu_op_o = ALU_SUBU;
      default:   alu_op_o = ALU_ADDU;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm
// Multi-cycle MIPS main controller. Sequences one instruction through
// FETCH -> DECODE -> EXEC/MEM/WB and drives the datapath strobes.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN: adds illegal_insn output and
// trap_ack input; ILLEGAL then waits for trap_ack instead of acting as a NOP.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode, funct       IR[31:26], IR[5:0]
//   zf                  ALU equality flag, used for beq/bne
//   mem_ready           memory completes current access this cycle
//   pc_we, pc_src       PC write enable and source select
//   ir_we, iord         IR write, memory address select
//   mem_rd, mem_wr      memory read / write requests
//   reg_we, reg_dst     register-file write and destination select
//   mem_to_reg          write-back source select
//   alu_src_a/b, alu_op ALU operand selects and operation code
//   state_o             current state for debug
//   illegal_insn/trap_ack (macro only) illegal instruction handshake
module mc_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int unsigned RESET_STATE_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zf,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [3:0] state_o
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_insn,
  input  logic       trap_ack
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_STATE_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       funct_valid;

  mc_alu_dec u_alu_dec (
    .state_i       (state_q),
    .opcode_i      (opcode),
    .funct_i       (funct),
    .alu_op_o      (alu_op),
    .funct_valid_o (funct_valid)
  );

  assign state_o = state_q;

  // State and INIT hold counter. Reset is asynchronous so every strobe drops
  // the moment rst_n falls, even mid memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state and strobe decode. Outputs are Moore on state/opcode except
  // pc_we/ir_we in FETCH (gated by mem_ready) and pc_we in BRANCH (gated by zf).
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_we      = 1'b0;
    iord       = IORD_PC;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = WB_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal_insn = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_FETCH;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      ST_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_we     = mem_ready;
        ir_we     = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = SRC_B_IMM_SH2;
        case (opcode)
          OP_RTYPE:                                   state_d = ST_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:                               state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                             state_d = ST_BRANCH;
          OP_J:                                       state_d = ST_JUMP;
          default:                                    state_d = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        state_d   = funct_valid ? ST_R_WB : ST_ILLEGAL;
      end
      ST_R_WB: begin
        reg_we  = 1'b1;
        reg_dst = REG_DST_RD;
        state_d = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_we  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = IORD_ALUOUT;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = WB_MDR;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = IORD_ALUOUT;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        pc_src    = PC_SRC_ALUOUT;
        pc_we     = (opcode == OP_BNE) ? ~zf : zf;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src  = PC_SRC_JUMP;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ILLEGAL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_insn = 1'b1;
        if (trap_ack) state_d = ST_FETCH;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm: a vector table of single instructions
// walked from FETCH back to FETCH, plus hand sequences for reset, memory
// wait states, reset during a wait and the illegal-instruction path.
// Build with MC_CTRL_ILLEGAL_TRAP_EN to cover the trap handshake.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zf;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [3:0] state_o;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_insn;
  logic       trap_ack;
`endif

  int checks = 0;
  int errors = 0;

  logic [16:0] dutOut;
  logic        watchRegWe;
  logic        sawRegWe;

  mc_ctrl_fsm #(.RESET_STATE_HOLD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zf         (zf),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .iord       (iord),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .state_o    (state_o)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_insn (illegal_insn),
    .trap_ack     (trap_ack)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All strobes packed into one word so a whole cycle is one comparison.
  assign dutOut = {pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  // Records any reg_we pulse inside the watched window.
  always @(reg_we or watchRegWe) begin
    if (watchRegWe && reg_we) sawRegWe = 1'b1;
  end

  // Hard stop if the bench ever gets lost.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] mkOut(
    input logic pcWe, input logic [1:0] pcSrc, input logic irWe,
    input logic iordV, input logic memRd, input logic memWr,
    input logic regWe, input logic regDst, input logic memToReg,
    input logic srcA, input logic [1:0] srcB, input logic [3:0] aluOp);
    return {pcWe, pcSrc, irWe, iordV, memRd, memWr, regWe, regDst,
            memToReg, srcA, srcB, aluOp};
  endfunction

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  execState;
    logic [16:0] execOut;
    int          ticksToFetch;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic mr);
    opcode    = op;
    funct     = fn;
    zf        = z;
    mem_ready = mr;
    #1;
  endtask

  localparam logic [16:0] OUT_ZERO   = 17'h0;
  localparam logic [3:0]  S_INIT     = 4'd0;
  localparam logic [3:0]  S_FETCH    = 4'd1;
  localparam logic [3:0]  S_DECODE   = 4'd2;

  initial begin
    logic [16:0] fetchOut;
    logic [16:0] decodeOut;
    logic [16:0] memRdOut;
    int steps;

    fetchOut  = mkOut(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'd0);
    decodeOut = mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'd0);
    memRdOut  = mkOut(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 4'd0);

    // name, opcode, funct, zf, exec state, exec outputs, cycles to FETCH
    vecs.push_back('{"nor",    6'h00, 6'h27, 1'b0, 4'd3,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd8),  2});
    vecs.push_back('{"add",    6'h00, 6'h20, 1'b0, 4'd3,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd3),  2});
    vecs.push_back('{"sub",    6'h00, 6'h22, 1'b0, 4'd3,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd4),  2});
    vecs.push_back('{"subu",   6'h00, 6'h23, 1'b0, 4'd3,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd1),  2});
    vecs.push_back('{"slt",    6'h00, 6'h2A, 1'b0, 4'd3,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd9),  2});
    vecs.push_back('{"sltu",   6'h00, 6'h2B, 1'b0, 4'd3,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd10), 2});
    vecs.push_back('{"badfn",  6'h00, 6'h00, 1'b0, 4'd3,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd0),  2});
    vecs.push_back('{"addi",   6'h08, 6'h00, 1'b0, 4'd5,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd11), 2});
    vecs.push_back('{"andi",   6'h0C, 6'h00, 1'b0, 4'd5,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd13), 2});
    vecs.push_back('{"ori",    6'h0D, 6'h00, 1'b0, 4'd5,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd2),  2});
    vecs.push_back('{"xori",   6'h0E, 6'h00, 1'b0, 4'd5,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd14), 2});
    vecs.push_back('{"lw",     6'h23, 6'h00, 1'b0, 4'd7,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0),  3});
    vecs.push_back('{"sw",     6'h2B, 6'h00, 1'b0, 4'd7,  mkOut(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0),  2});
    vecs.push_back('{"beq_z1", 6'h04, 6'h00, 1'b1, 4'd11, mkOut(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd1),  1});
    vecs.push_back('{"bne_z1", 6'h05, 6'h00, 1'b1, 4'd11, mkOut(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd1),  1});
    vecs.push_back('{"beq_z0", 6'h04, 6'h00, 1'b0, 4'd11, mkOut(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd1),  1});
    vecs.push_back('{"bne_z0", 6'h05, 6'h00, 1'b0, 4'd11, mkOut(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd1),  1});
    vecs.push_back('{"j",      6'h02, 6'h00, 1'b0, 4'd12, mkOut(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0),  1});
    vecs.push_back('{"ill3f",  6'h3F, 6'h00, 1'b0, 4'd13, OUT_ZERO,                                                1});

    // Reset: everything quiet while rst_n is low.
    watchRegWe = 1'b0;
    sawRegWe   = 1'b0;
    rst_n      = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    trap_ack = 1'b0;
`endif
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_state", 32'(state_o), 32'(S_INIT));
    checkOutput("rst_out", 32'(dutOut), 32'(OUT_ZERO));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    checkOutput("rst_illegal", 32'(illegal_insn), 32'd0);
`endif

    // Release: one cycle of INIT, then FETCH with the read completing.
    rst_n = 1'b1;
    #1;
    checkOutput("init_state", 32'(state_o), 32'(S_INIT));
    checkOutput("init_out", 32'(dutOut), 32'(OUT_ZERO));
    tick();
    checkOutput("fetch_state", 32'(state_o), 32'(S_FETCH));
    checkOutput("fetch_out", 32'(dutOut), 32'(fetchOut));

    // Table: each instruction from FETCH through its execute state and back.
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    trap_ack = 1'b1;
`endif
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].z, 1'b1);
      tick();
      checkOutput({vecs[i].name, "_dec_state"}, 32'(state_o), 32'(S_DECODE));
      checkOutput({vecs[i].name, "_dec_out"}, 32'(dutOut), 32'(decodeOut));
      tick();
      checkOutput({vecs[i].name, "_exe_state"}, 32'(state_o), 32'(vecs[i].execState));
      checkOutput({vecs[i].name, "_exe_out"}, 32'(dutOut), 32'(vecs[i].execOut));
      steps = 0;
      while (state_o != S_FETCH && steps < 8) begin
        tick();
        steps++;
      end
      checkOutput({vecs[i].name, "_ticks"}, 32'(steps), 32'(vecs[i].ticksToFetch));
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    trap_ack = 1'b0;
`endif

    // FETCH stall: no PC/IR write until the read completes.
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
    checkOutput("fstall_out", 32'(dutOut),
                32'(mkOut(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'd0)));
    tick();
    checkOutput("fstall_state", 32'(state_o), 32'(S_FETCH));

    // lw with three wait cycles in MEM_RD, then MEM_WB.
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checkOutput("lw_wait_state", 32'(state_o), 32'd8);
      checkOutput("lw_wait_out", 32'(dutOut), 32'(memRdOut));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("lw_last_state", 32'(state_o), 32'd8);
    checkOutput("lw_last_out", 32'(dutOut), 32'(memRdOut));
    tick();
    checkOutput("lw_wb_state", 32'(state_o), 32'd9);
    checkOutput("lw_wb_out", 32'(dutOut),
                32'(mkOut(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'd0)));
    tick();
    checkOutput("lw_done_state", 32'(state_o), 32'(S_FETCH));

    // Reset during a MEM_RD wait: INIT at once, no register write escapes.
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    checkOutput("rstw_pre_state", 32'(state_o), 32'd8);
    sawRegWe   = 1'b0;
    watchRegWe = 1'b1;
    rst_n      = 1'b0;
    #1;
    checkOutput("rstw_state", 32'(state_o), 32'(S_INIT));
    checkOutput("rstw_out", 32'(dutOut), 32'(OUT_ZERO));
    mem_ready = 1'b1;
    tick();
    tick();
    checkOutput("rstw_hold_state", 32'(state_o), 32'(S_INIT));
    rst_n = 1'b1;
    tick();
    checkOutput("rstw_fetch_state", 32'(state_o), 32'(S_FETCH));
    watchRegWe = 1'b0;
    checkOutput("rstw_no_regwe", 32'(sawRegWe), 32'd0);

    // Illegal opcode 0x3F.
    applyStimulus(6'h3F, 6'h00, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("ill_state", 32'(state_o), 32'd13);
    checkOutput("ill_out", 32'(dutOut), 32'(OUT_ZERO));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    checkOutput("ill_flag", 32'(illegal_insn), 32'd1);
    tick();
    checkOutput("ill_hold1_state", 32'(state_o), 32'd13);
    checkOutput("ill_hold1_flag", 32'(illegal_insn), 32'd1);
    tick();
    checkOutput("ill_hold2_state", 32'(state_o), 32'd13);
    trap_ack = 1'b1;
    tick();
    checkOutput("ill_ack_state", 32'(state_o), 32'(S_FETCH));
    checkOutput("ill_ack_flag", 32'(illegal_insn), 32'd0);
`else
    tick();
    checkOutput("ill_nop_state", 32'(state_o), 32'(S_FETCH));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
